// File: rtl/buffer_store_ctrl.sv
// ----------------------------------------------------------------------------
// buffer_store_ctrl
//   Sequencing controller for one buffer_store instance holding
//   N = CO*SIZE*SIZE activations. It admits upstream elements with a
//   valid/ready handshake until the buffer is full. It then gives buffer_store
//   one extra ce so that it can latch its full flag, and pulses o_start to the
//   downstream consumer. After the consumer reports i_done, it clears the
//   buffer and starts the next frame.
//
// Ports
//   clk          rising-edge clock
//   global_rst   asynchronous reset, active-high
//   i_en         run enable; looked at only in IDLE and CLEAR
//   i_valid      upstream element valid
//   o_ready      element accepted this cycle when i_valid is also high
//   o_buf_ce     buffer_store ce
//   o_buf_clr    buffer_store rst_processEnd
//   o_start      one-cycle pulse: buffer contents valid for the consumer
//   i_done       single-cycle pulse from the consumer: buffer released
//   o_busy       controller is not in IDLE
//   o_err        sticky protocol error, cleared only by reset
//   o_elem_cnt   elements accepted in the current frame (0..N)
//   o_frame_cnt  completed frames, wraps modulo 2^FW
//
// State table
//   state   | meaning
//   IDLE    | stopped; waits for i_en
//   FILL    | accepting elements; ce follows i_valid
//   HOLD    | one extra ce so buffer_store latches its full flag
//   START   | o_start pulse to the consumer
//   WAIT    | buffer stable; waits for i_done
//   CLEAR   | buffer clear; frame counted; i_en selects FILL or IDLE
// ----------------------------------------------------------------------------
module buffer_store_ctrl #(
    parameter  int SIZE = 5,
    parameter  int CO   = 4,
    parameter  int FW   = 8,
    localparam int N    = CO * SIZE * SIZE,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          global_rst,
    input  logic          i_en,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_buf_ce,
    output logic          o_buf_clr,
    output logic          o_start,
    input  logic          i_done,
    output logic          o_busy,
    output logic          o_err,
    output logic [CW-1:0] o_elem_cnt,
    output logic [FW-1:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_HOLD,
        S_START,
        S_WAIT,
        S_CLEAR
    } state_t;

    localparam logic [CW-1:0] LP_LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_elem_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic          r_err;
    logic          w_beat;
    logic          w_done_err;
    logic          w_overrun_err;

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_ready   = 1'b0;
        o_buf_ce  = 1'b0;
        o_buf_clr = 1'b0;
        o_start   = 1'b0;
        o_busy    = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_en) w_next = S_FILL;
            end
            S_FILL: begin
                // i_en is deliberately not looked at here: a frame in
                // progress always runs to completion.
                o_ready  = 1'b1;
                o_buf_ce = i_valid;
                if (i_valid && (r_elem_cnt == LP_LAST)) w_next = S_HOLD;
            end
            S_HOLD: begin
                // The buffer counter is already at N, so this ce writes no
                // data. It only lets buffer_store register o_full.
                o_buf_ce = 1'b1;
                w_next   = S_START;
            end
            S_START: begin
                o_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (i_done) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                o_buf_clr = 1'b1;
                w_next    = i_en ? S_FILL : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_beat = i_valid & o_ready;

    // A stray done outside WAIT, or an element offered while the buffer is
    // being handed over, is flagged and otherwise ignored.
    assign w_done_err    = i_done && (r_state != S_WAIT);
    assign w_overrun_err = i_valid && i_en &&
                           ((r_state == S_HOLD) || (r_state == S_START) ||
                            (r_state == S_WAIT) || (r_state == S_CLEAR));

    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            r_elem_cnt  <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_elem_cnt  <= '0;
                r_frame_cnt <= r_frame_cnt + FW'(1);
            end else if (w_beat) begin
                r_elem_cnt  <= r_elem_cnt + CW'(1);
            end
            if (w_done_err || w_overrun_err) r_err <= 1'b1;
        end
    end

    assign o_err       = r_err;
    assign o_elem_cnt  = r_elem_cnt;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_buffer_store_ctrl.sv
// ----------------------------------------------------------------------------
// tb_buffer_store_ctrl
//   Self-checking bench for buffer_store_ctrl. Two instances share the same
//   stimulus: dut_a uses FW=8 and dut_b uses FW=2, so frame-counter wrap can be
//   observed directly. Each expected frame count is queued when a frame is
//   launched. It is popped and compared once the controller leaves CLEAR.
// ----------------------------------------------------------------------------
module tb_buffer_store_ctrl;

    localparam int SIZE = 5;
    localparam int CO   = 4;
    localparam int N    = CO * SIZE * SIZE;
    localparam int CW   = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          global_rst;
    logic          i_en, i_valid, i_done;

    logic          a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err;
    logic [CW-1:0] a_elem_cnt;
    logic [7:0]    a_frame_cnt;
    logic          b_ready, b_buf_ce, b_buf_clr, b_start, b_busy, b_err;
    logic [CW-1:0] b_elem_cnt;
    logic [1:0]    b_frame_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int frames_done = 0;
    int exp_frame_q[$];
    int inv_ce_clr = 0;
    int inv_cnt = 0;
    int inv_ab = 0;

    buffer_store_ctrl #(.SIZE(SIZE), .CO(CO), .FW(8)) dut_a (
        .clk(clk), .global_rst(global_rst), .i_en(i_en), .i_valid(i_valid),
        .o_ready(a_ready), .o_buf_ce(a_buf_ce), .o_buf_clr(a_buf_clr),
        .o_start(a_start), .i_done(i_done), .o_busy(a_busy), .o_err(a_err),
        .o_elem_cnt(a_elem_cnt), .o_frame_cnt(a_frame_cnt)
    );

    buffer_store_ctrl #(.SIZE(SIZE), .CO(CO), .FW(2)) dut_b (
        .clk(clk), .global_rst(global_rst), .i_en(i_en), .i_valid(i_valid),
        .o_ready(b_ready), .o_buf_ce(b_buf_ce), .o_buf_clr(b_buf_clr),
        .o_start(b_start), .i_done(i_done), .o_busy(b_busy), .o_err(b_err),
        .o_elem_cnt(b_elem_cnt), .o_frame_cnt(b_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_buf_ce && a_buf_clr) inv_ce_clr++;
        if (int'(a_elem_cnt) > N) inv_cnt++;
        if ({b_ready, b_buf_ce, b_buf_clr, b_start, b_busy, b_err, b_elem_cnt} !==
            {a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err, a_elem_cnt})
            inv_ab++;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame from its first FILL cycle through CLEAR and returns
    // #1 after the edge that leaves CLEAR.
    task automatic do_frame(input bit toggle, input int drop_en_at, input int done_at,
                            input bit valid_wait, input int done_delay);
        int beats = 0;
        int t = 0;
        int t_last = -1;
        int ce_fill = 0;
        int gap_ce = 0;
        int cnt_bad = 0;
        int early_start = 0;
        int wait_bad = 0;
        int exp_f;
        bit ph = 1'b1;
        bit done_sent = 1'b0;
        exp_frame_q.push_back(frames_done + 1);
        while (beats < N && t < 1000) begin
            i_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            if (drop_en_at >= 0 && beats == drop_en_at) i_en = 1'b0;
            i_done = 1'b0;
            if (done_at >= 0 && beats == done_at && !done_sent) begin
                i_done = 1'b1;
                done_sent = 1'b1;
            end
            @(negedge clk);
            if (a_buf_ce) ce_fill++;
            if (!i_valid && a_buf_ce) gap_ce++;
            if (int'(a_elem_cnt) != beats) cnt_bad++;
            if (a_start) early_start++;
            if (i_valid && a_ready) begin
                beats++;
                t_last = t;
            end
            t++;
            adv();
        end
        n_checks++;
        if (beats != N) begin
            n_fail++;
            $display("FAIL fill_timeout: accepted %0d beats, required %0d", beats, N);
            return;
        end
        n_checks++;
        if (ce_fill != N) begin
            n_fail++;
            $display("FAIL fill_ce_count: got %0d, required %0d", ce_fill, N);
        end
        n_checks++;
        if (gap_ce != 0 || early_start != 0 || cnt_bad != 0) begin
            n_fail++;
            $display("FAIL fill_cycle: gap_ce=%0d early_start=%0d cnt_bad=%0d, required 0 0 0",
                     gap_ce, early_start, cnt_bad);
        end
        n_checks++;
        if (t_last + 2 != (toggle ? 2 * N : N + 1)) begin
            n_fail++;
            $display("FAIL start_from_fill: got %0d, required %0d", t_last + 2,
                     toggle ? 2 * N : N + 1);
        end
        i_valid = valid_wait;
        i_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_buf_ce, a_ready, a_start} !== 3'b100 || int'(a_elem_cnt) != N) begin
            n_fail++;
            $display("FAIL hold: ce/ready/start=%b%b%b cnt=%0d, required 100 cnt=%0d",
                     a_buf_ce, a_ready, a_start, a_elem_cnt, N);
        end
        adv();
        @(negedge clk);
        n_checks++;
        if ({a_start, a_buf_ce, a_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL start_pulse: start/ce/ready=%b%b%b, required 100",
                     a_start, a_buf_ce, a_ready);
        end
        adv();
        for (int k = 1; k < done_delay; k++) begin
            @(negedge clk);
            if (a_start || a_buf_ce || a_buf_clr || !a_busy) wait_bad++;
            adv();
        end
        i_done = 1'b1;
        @(negedge clk);
        if (a_buf_clr || a_start || a_buf_ce) wait_bad++;
        n_checks++;
        if (wait_bad != 0) begin
            n_fail++;
            $display("FAIL wait_quiet: %0d bad cycles, required 0", wait_bad);
        end
        adv();
        i_done = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_buf_clr, a_buf_ce, a_ready, a_start} !== 4'b1000) begin
            n_fail++;
            $display("FAIL clear: clr/ce/ready/start=%b%b%b%b, required 1000",
                     a_buf_clr, a_buf_ce, a_ready, a_start);
        end
        adv();
        frames_done++;
        exp_f = exp_frame_q.pop_front();
        n_checks++;
        if (int'(a_frame_cnt) != exp_f % 256 || int'(b_frame_cnt) != exp_f % 4) begin
            n_fail++;
            $display("FAIL frame_cnt: got a=%0d b=%0d, required a=%0d b=%0d",
                     a_frame_cnt, b_frame_cnt, exp_f % 256, exp_f % 4);
        end
        n_checks++;
        if (a_elem_cnt !== '0) begin
            n_fail++;
            $display("FAIL elem_cnt_cleared: got %0d, required 0", a_elem_cnt);
        end
    endtask

    task automatic test_reset();
        global_rst = 1'b1;
        i_en = 1'b0;
        i_valid = 1'b0;
        i_done = 1'b0;
        #1;
        n_checks++;
        if ({a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err} !== 6'b0 ||
            a_elem_cnt !== '0 || a_frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: outs=%b cnt=%0d frame=%0d, required all 0",
                     {a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err},
                     a_elem_cnt, a_frame_cnt);
        end
        i_en = 1'b1;
        i_valid = 1'b1;
        i_done = 1'b1;
        adv();
        adv();
        n_checks++;
        if ({a_ready, a_buf_ce, a_busy, a_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_wins: outs=%b, required 0000",
                     {a_ready, a_buf_ce, a_busy, a_err});
        end
        global_rst = 1'b0;
        i_en = 1'b0;
        i_done = 1'b0;
        adv();
        @(negedge clk);
        n_checks++;
        if ({a_ready, a_buf_ce, a_busy, a_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: outs=%b, required 0000",
                     {a_ready, a_buf_ce, a_busy, a_err});
        end
        adv();
    endtask

    task automatic test_continuous();
        i_en = 1'b1;
        i_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_buf_ce, a_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_ce: ce/ready=%b%b, required 00", a_buf_ce, a_ready);
        end
        adv();
        do_frame(1'b0, -1, -1, 1'b0, 10);
    endtask

    task automatic test_toggle();
        do_frame(1'b1, -1, -1, 1'b0, 4);
    endtask

    task automatic test_en_drop();
        int bad = 0;
        do_frame(1'b0, 40, -1, 1'b0, 3);
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_busy || a_ready || a_buf_ce) bad++;
            adv();
        end
        n_checks++;
        if (bad != 0 || a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_idle: bad=%0d err=%b, required 0 0", bad, a_err);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_err();
        i_en = 1'b1;
        i_valid = 1'b0;
        adv();
        do_frame(1'b0, -1, 20, 1'b1, 5);
        n_checks++;
        if (a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b, required 1", a_err);
        end
        i_en = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 5; k++) adv();
        n_checks++;
        if (a_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b, required 1", a_err);
        end
    endtask

    task automatic test_async_reset();
        int beats = 0;
        int guard = 0;
        i_valid = 1'b1;
        while (beats < 37 && guard < 200) begin
            @(negedge clk);
            if (a_ready) beats++;
            guard++;
            adv();
        end
        @(negedge clk);
        n_checks++;
        if (int'(a_elem_cnt) != 37) begin
            n_fail++;
            $display("FAIL pre_reset_cnt: got %0d, required 37", a_elem_cnt);
        end
        #2;
        global_rst = 1'b1;
        #1;
        n_checks++;
        if ({a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err} !== 6'b0 ||
            a_elem_cnt !== '0 || a_frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b cnt=%0d frame=%0d, required all 0",
                     {a_ready, a_buf_ce, a_buf_clr, a_start, a_busy, a_err},
                     a_elem_cnt, a_frame_cnt);
        end
        adv();
        global_rst = 1'b0;
        frames_done = 0;
        i_en = 1'b1;
        i_valid = 1'b0;
        adv();
        do_frame(1'b0, -1, -1, 1'b0, 4);
    endtask

    task automatic test_back_to_back();
        global_rst = 1'b1;
        i_en = 1'b0;
        i_valid = 1'b0;
        #3;
        global_rst = 1'b0;
        frames_done = 0;
        i_en = 1'b1;
        adv();
        for (int f = 0; f < 5; f++) do_frame(1'b0, -1, -1, 1'b0, 2);
        n_checks++;
        if (a_err !== 1'b0 || b_err !== 1'b0 || int'(a_frame_cnt) != 5) begin
            n_fail++;
            $display("FAIL back_to_back: err=%b%b frame_a=%0d, required 00 5",
                     a_err, b_err, a_frame_cnt);
        end
    endtask

    task automatic test_invariants();
        n_checks++;
        if (inv_ce_clr != 0 || inv_cnt != 0 || inv_ab != 0) begin
            n_fail++;
            $display("FAIL invariants: ce_with_clr=%0d cnt_over_n=%0d a_b_diff=%0d, required 0 0 0",
                     inv_ce_clr, inv_cnt, inv_ab);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_en_drop();
        test_err();
        test_async_reset();
        test_back_to_back();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buffer_store_ctrl.md
Name: buffer_store_ctrl

Overview:
Sequencing controller for one buffer_store instance holding N = CO*SIZE*SIZE activations. It gates the upstream element stream into the buffer using a valid/ready handshake. When the buffer is full it issues a start pulse to the downstream consumer (FC layer) and waits for that consumer's done. It then clears the buffer and begins the next frame.

Parameters:
SIZE, 5, spatial edge of one channel map; must match the buffer_store SIZE
CO, 4, channel count; must match the buffer_store CO
FW, 8, width of the frame counter
(localparam N = CO*SIZE*SIZE; localparam CW = clog2(N+1))

Ports:
clk  in  1  clock, rising edge
global_rst  in  1  asynchronous reset, active-high
i_en  in  1  run enable; sampled only in IDLE and CLEAR
i_valid  in  1  upstream element valid
o_ready  out  1  controller accepts an element this cycle
o_buf_ce  out  1  drives buffer_store ce
o_buf_clr  out  1  drives buffer_store rst_processEnd
o_start  out  1  one-cycle pulse: buffer contents valid for consumer
i_done  in  1  consumer finished with buffer; single-cycle pulse
o_busy  out  1  state != IDLE
o_err  out  1  sticky protocol error
o_elem_cnt  out  CW  elements accepted in current frame
o_frame_cnt  out  FW  completed frames, wraps modulo 2^FW

Behaviour:
- Reset (global_rst=1, asynchronous):
  - state=IDLE.
  - o_elem_cnt=0, o_frame_cnt=0, o_err=0.
  - All outputs 0.
  - Reset overrides every state, including mid-frame.
- FSM states: IDLE, FILL, HOLD, START, WAIT, CLEAR. Transitions are registered.
- Moore outputs:
  - o_ready=1 only in FILL.
  - o_start=1 only in START.
  - o_buf_clr=1 only in CLEAR.
  - o_busy=1 in every state except IDLE.
- Mealy output: o_buf_ce = (FILL & i_valid) | HOLD.
- Beat accepted = i_valid & o_ready.
- IDLE: if i_en=1, go to FILL on the next cycle. i_valid is ignored in IDLE.
- FILL:
  - Each accepted beat increments o_elem_cnt.
  - When a beat is accepted with o_elem_cnt==N-1: o_elem_cnt becomes N and the next state is HOLD.
  - Gaps in i_valid stall the FSM indefinitely with no timeout.
  - i_en is ignored; a frame in progress always completes.
- HOLD (1 cycle):
  - o_ready=0, o_buf_ce=1.
  - This extra ce lets buffer_store latch o_full (its counter is already at N, so no data is written).
  - Next state: START.
- START (1 cycle): o_start=1. Next state: WAIT.
- WAIT:
  - Hold until i_done=1, then go to CLEAR.
  - Buffer contents are stable; no ce or clr is issued.
- CLEAR (1 cycle):
  - o_buf_clr=1.
  - o_elem_cnt returns to 0 on the transition out.
  - o_frame_cnt increments (wraps 2^FW-1 -> 0).
  - Next state: FILL if i_en=1, else IDLE.
- Latency:
  - First o_buf_ce is in the cycle after i_en is sampled in IDLE (given i_valid=1).
  - o_start occurs 2 cycles after the cycle of the N-th accepted beat.
  - o_buf_clr occurs 1 cycle after i_done.
  - With i_en held high, the first beat of the next frame can be accepted 1 cycle after CLEAR.
- Error conditions: o_err is set, and held until reset, on either of:
  - i_done=1 in any state other than WAIT;
  - i_valid=1 in HOLD, START, WAIT or CLEAR while i_en=1 (upstream overran the frame).
  - In both cases the FSM is unaffected and the stray input is ignored.
- Simultaneous events:
  - i_done and i_en in CLEAR: i_done counts as an error; i_en still selects FILL.
  - Reset with any input: reset wins.
- Width rules:
  - o_elem_cnt never exceeds N.
  - o_buf_ce is never asserted while o_buf_clr=1.

Test Plan:
- Defaults SIZE=5, CO=4 (N=100). Reset, then i_en=1 held, i_valid=1 continuous, i_done pulsed 10 cycles after o_start:
  - o_buf_ce high for 101 consecutive cycles (100 FILL + 1 HOLD);
  - o_start pulses once, 2 cycles after the 100th beat;
  - o_buf_clr pulses 1 cycle after i_done;
  - o_frame_cnt 0 -> 1.
- i_valid toggling 1,0,1,0 in FILL:
  - exactly 100 accepted beats;
  - o_elem_cnt reaches 100 on the cycle after the 100th beat (that beat is accepted at o_elem_cnt=99);
  - no ce pulses while i_valid=0, except the HOLD ce;
  - o_start occurs about 200 cycles after FILL entry.
- i_en dropped at beat 40:
  - frame completes through CLEAR;
  - FSM returns to IDLE;
  - o_busy=0;
  - o_ready=0 afterwards.
- i_done pulsed at beat 20, and i_valid=1 during WAIT:
  - o_err=1 and stays 1;
  - o_start and o_frame_cnt still correct.
- global_rst asserted after 37 beats:
  - all outputs 0 asynchronously;
  - after release with i_en=1, a full 100 beats are required before o_start.
- FW=2, 5 back-to-back frames: o_frame_cnt sequence 1,2,3,0,1; o_err stays 0.
